debug_step_unit: RTL and testbench
==================================

DEBUG_STEP_UNIT -- requirements
Module: debug_step_unit

Interface
REQ-001 Parameter NB_WORD, 32, data/instruction word width (multiple of 8).
REQ-002 Parameter N_REGS, 32, register-file entries dumped.
REQ-003 Parameter N_MEM, 32, data-memory words dumped.
REQ-004 Parameter IMEM_DEPTH, 64, instruction-memory depth in words.
REQ-005 Parameter NB_LATCH, 341, pipeline-latch snapshot width.
REQ-006 Parameter HALT_CODE, 32'hFC000000, end-of-program instruction.
REQ-007 i_du_clk  in  1  sole clock; all state changes on rising edge.
REQ-008 i_du_reset  in  1  synchronous, active-high reset.
REQ-009 i_rx_empty  in  1  RX FIFO empty.
REQ-010 i_rx_data  in  8  RX FIFO head byte.
REQ-011 o_rx_rd  out  1  one-cycle pop of RX FIFO.
REQ-012 i_tx_full  in  1  TX FIFO full.
REQ-013 o_tx_wr  out  1  one-cycle push of o_tx_data.
REQ-014 o_tx_data  out  8  byte pushed to TX FIFO.
REQ-015 i_halt  in  1  processor reached halt.
REQ-016 o_cpu_en  out  1  processor clock-enable.
REQ-017 o_cpu_reset  out  1  processor reset pulse.
REQ-018 o_imem_we  out  1  instruction-memory write strobe.
REQ-019 o_imem_addr  out  NB_WORD  byte address (word index x4).
REQ-020 o_imem_data  out  NB_WORD  instruction to write.
REQ-021 o_reg_addr  out  clog2(N_REGS)  register read index; i_reg_data combinational, valid same cycle.
REQ-022 i_reg_data  in  NB_WORD  register read data.
REQ-023 o_mem_addr  out  NB_WORD  data-memory byte address; i_mem_data valid same cycle.
REQ-024 i_mem_data  in  NB_WORD  data-memory read data.
REQ-025 i_latch_data  in  NB_LATCH  latch snapshot.
REQ-026 o_state  out  4  current state code for LEDs.

Function
REQ-027 States: IDLE, CMD, ACK, LOAD, WRITE, RUN, STEP, DUMP_REG, DUMP_MEM, DUMP_LAT, CPU_RST.
REQ-028 RX consume rule: o_rx_rd=1 only in a cycle where the state consumes a byte and i_rx_empty=0; consumed byte is i_rx_data that same cycle; if empty, state holds, no pop.
REQ-029 TX rule: o_tx_wr=1 only when i_tx_full=0; byte valid same cycle; if full, state and counters hold, no push.
REQ-030 IDLE -> CMD when i_rx_empty=0 (no pop in IDLE).
REQ-031 CMD pops one byte: 0x02 -> ACK then LOAD (word index cleared); 0x05 -> ACK then RUN; 0x06 -> ACK then STEP; 0x0D -> ACK then DUMP_REG; 0x0C -> CPU_RST; other -> send 0x55 (NAK) then IDLE.
REQ-032 ACK pushes 0xAA once, then enters the pending state.
REQ-033 LOAD pops NB_WORD/8 bytes big-endian (first byte to MSB), each byte answered by 0xAA via ACK; after last byte -> WRITE.
REQ-034 WRITE: o_imem_we=1 for exactly one cycle with assembled word at o_imem_addr=index*4; then if word==HALT_CODE or index==IMEM_DEPTH-1 -> IDLE with index cleared, else index+1 -> LOAD.
REQ-035 RUN: o_cpu_en=1 every cycle until i_halt=1; cycle i_halt seen: o_cpu_en=0, -> DUMP_REG.
REQ-036 STEP: o_cpu_en=1 for exactly one cycle, then -> DUMP_REG regardless of i_halt.
REQ-037 DUMP_REG: for index 0..N_REGS-1, push NB_WORD/8 bytes of i_reg_data MSB-first with o_reg_addr=index; then -> DUMP_MEM.
REQ-038 DUMP_MEM: same for index 0..N_MEM-1, o_mem_addr=index*4; then -> DUMP_LAT.
REQ-039 DUMP_LAT: push ceil(NB_LATCH/8) bytes MSB-first; latch vector zero-extended at MSB to a byte multiple; last byte 0x5A terminator follows; -> IDLE.
REQ-040 Total dump length = 4*N_REGS + 4*N_MEM + ceil(NB_LATCH/8) + 1 bytes for NB_WORD=32.
REQ-041 CPU_RST: o_cpu_reset=1 one cycle, index and assembled word cleared, -> IDLE.
REQ-042 i_halt ignored outside RUN; RX bytes arriving during RUN/STEP/DUMP remain in FIFO, unpopped.
REQ-043 o_cpu_en=0 in every state other than RUN/STEP.

Reset
REQ-044 i_du_reset=1 at any cycle, mid-operation included: next state IDLE; counters, index, assembled word = 0; all strobes, o_cpu_en, o_tx_data = 0; o_imem/reg/mem addresses = 0.

Verification
REQ-045 LOAD: bytes 02, 20,01,00,05, FC,00,00,00 -> 0xAA x9; WRITE addr 0 data 0x20010005, addr 4 data 0xFC000000; back to IDLE.
REQ-046 RUN: 05, i_halt after 10 cycles -> 0xAA, o_cpu_en high 10 cycles, then 4*32+4*32+43+1=300 bytes ending 0x5A; first 4 bytes = reg0 MSB-first.
REQ-047 STEP: 06 -> 0xAA, o_cpu_en high exactly 1 cycle, full 300-byte dump.
REQ-048 Backpressure: hold i_tx_full=1 for 5 cycles mid-dump -> no o_tx_wr, no byte lost/duplicated versus reference stream.
REQ-049 Byte 0x77 -> single 0x55, IDLE; byte 0x0C -> o_cpu_reset one-cycle pulse, no TX.
REQ-050 Assert i_du_reset during DUMP_MEM -> IDLE next cycle, all outputs 0, later 05 command yields full dump from reg0.

Source files
------------

// File: rtl/debug_step_unit.sv
// rtl/debug_step_unit.sv - UART-driven debug unit: program load, run/step, and state dump
// Bytes arrive from an RX FIFO, replies and dump bytes leave through a TX FIFO.
module debug_step_unit #(
  parameter int NB_WORD = 32,
  parameter int N_REGS = 32,
  parameter int N_MEM = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int NB_LATCH = 341,
  parameter logic [NB_WORD-1:0] HALT_CODE = 32'hFC000000,
  localparam int NB_RADDR = $clog2(N_REGS)
) (
  input  logic                i_du_clk,
  input  logic                i_du_reset,
  input  logic                i_rx_empty,
  input  logic [7:0]          i_rx_data,
  output logic                o_rx_rd,
  input  logic                i_tx_full,
  output logic                o_tx_wr,
  output logic [7:0]          o_tx_data,
  input  logic                i_halt,
  output logic                o_cpu_en,
  output logic                o_cpu_reset,
  output logic                o_imem_we,
  output logic [NB_WORD-1:0]  o_imem_addr,
  output logic [NB_WORD-1:0]  o_imem_data,
  output logic [NB_RADDR-1:0] o_reg_addr,
  input  logic [NB_WORD-1:0]  i_reg_data,
  output logic [NB_WORD-1:0]  o_mem_addr,
  input  logic [NB_WORD-1:0]  i_mem_data,
  input  logic [NB_LATCH-1:0] i_latch_data,
  output logic [3:0]          o_state
);

  localparam int NBYTES = NB_WORD / 8;
  localparam int NB_LBYTES = (NB_LATCH + 7) / 8;
  localparam int NB_LPAD = NB_LBYTES * 8;
  localparam logic [7:0] LAST_BYTE = 8'(NBYTES - 1);
  localparam logic [15:0] LAST_REG = 16'(N_REGS - 1);
  localparam logic [15:0] LAST_MEM = 16'(N_MEM - 1);
  localparam logic [15:0] LAST_IMEM = 16'(IMEM_DEPTH - 1);
  localparam logic [15:0] LAT_END = 16'(NB_LBYTES);

  typedef enum logic [3:0] {
    IDLE, CMD, ACK, LOAD, WRITE, RUN, STEP, DUMP_REG, DUMP_MEM, DUMP_LAT, CPU_RST
  } state_t;

  state_t state, state_n, ack_next, ack_next_n;
  logic [7:0] ack_byte, ack_byte_n;
  logic [15:0] idx, idx_n;
  logic [7:0] byte_cnt, byte_cnt_n;
  logic [NB_WORD-1:0] word, word_n;

  logic [NB_WORD-1:0] reg_sh, mem_sh;
  logic [NB_LPAD-1:0] lat_pad, lat_sh;

  // Selected dump byte always sits in the top byte after shifting.
  assign reg_sh = i_reg_data << {byte_cnt, 3'b000};
  assign mem_sh = i_mem_data << {byte_cnt, 3'b000};
  assign lat_pad = NB_LPAD'(i_latch_data);
  assign lat_sh = lat_pad << {idx, 3'b000};

  assign o_imem_addr = NB_WORD'({idx, 2'b00});
  assign o_mem_addr = NB_WORD'({idx, 2'b00});
  assign o_reg_addr = idx[NB_RADDR-1:0];
  assign o_imem_data = word;
  assign o_state = state;

  always_ff @(posedge i_du_clk) begin
    if (i_du_reset) begin
      state <= IDLE;
      ack_next <= IDLE;
      ack_byte <= 8'h00;
      idx <= '0;
      byte_cnt <= '0;
      word <= '0;
    end else begin
      state <= state_n;
      ack_next <= ack_next_n;
      ack_byte <= ack_byte_n;
      idx <= idx_n;
      byte_cnt <= byte_cnt_n;
      word <= word_n;
    end
  end

  always_comb begin
    state_n = state;
    ack_next_n = ack_next;
    ack_byte_n = ack_byte;
    idx_n = idx;
    byte_cnt_n = byte_cnt;
    word_n = word;
    o_rx_rd = 1'b0;
    o_tx_wr = 1'b0;
    o_tx_data = 8'h00;
    o_cpu_en = 1'b0;
    o_cpu_reset = 1'b0;
    o_imem_we = 1'b0;
    case (state)
      IDLE: if (!i_rx_empty) state_n = CMD;
      CMD: begin
        if (!i_rx_empty) begin
          o_rx_rd = 1'b1;
          ack_byte_n = 8'hAA;
          state_n = ACK;
          case (i_rx_data)
            8'h02: begin
              ack_next_n = LOAD;
              idx_n = '0;
              byte_cnt_n = '0;
              word_n = '0;
            end
            8'h05: ack_next_n = RUN;
            8'h06: ack_next_n = STEP;
            8'h0D: begin
              ack_next_n = DUMP_REG;
              idx_n = '0;
              byte_cnt_n = '0;
            end
            8'h0C: state_n = CPU_RST;
            default: begin
              ack_byte_n = 8'h55;
              ack_next_n = IDLE;
            end
          endcase
        end
      end
      ACK: begin
        o_tx_data = ack_byte;
        if (!i_tx_full) begin
          o_tx_wr = 1'b1;
          state_n = ack_next;
        end
      end
      LOAD: begin
        if (!i_rx_empty) begin
          o_rx_rd = 1'b1;
          word_n = {word[NB_WORD-9:0], i_rx_data};
          ack_byte_n = 8'hAA;
          state_n = ACK;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_n = '0;
            ack_next_n = WRITE;
          end else begin
            byte_cnt_n = byte_cnt + 8'd1;
            ack_next_n = LOAD;
          end
        end
      end
      WRITE: begin
        o_imem_we = 1'b1;
        word_n = '0;
        if (word == HALT_CODE || idx == LAST_IMEM) begin
          idx_n = '0;
          state_n = IDLE;
        end else begin
          idx_n = idx + 16'd1;
          state_n = LOAD;
        end
      end
      RUN: begin
        if (i_halt) begin
          idx_n = '0;
          byte_cnt_n = '0;
          state_n = DUMP_REG;
        end else begin
          o_cpu_en = 1'b1;
        end
      end
      STEP: begin
        o_cpu_en = 1'b1;
        idx_n = '0;
        byte_cnt_n = '0;
        state_n = DUMP_REG;
      end
      DUMP_REG: begin
        o_tx_data = reg_sh[NB_WORD-1 -: 8];
        if (!i_tx_full) begin
          o_tx_wr = 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_n = '0;
            if (idx == LAST_REG) begin
              idx_n = '0;
              state_n = DUMP_MEM;
            end else begin
              idx_n = idx + 16'd1;
            end
          end else begin
            byte_cnt_n = byte_cnt + 8'd1;
          end
        end
      end
      DUMP_MEM: begin
        o_tx_data = mem_sh[NB_WORD-1 -: 8];
        if (!i_tx_full) begin
          o_tx_wr = 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_n = '0;
            if (idx == LAST_MEM) begin
              idx_n = '0;
              state_n = DUMP_LAT;
            end else begin
              idx_n = idx + 16'd1;
            end
          end else begin
            byte_cnt_n = byte_cnt + 8'd1;
          end
        end
      end
      DUMP_LAT: begin
        // idx counts latch bytes here; one extra slot carries the terminator
        o_tx_data = (idx == LAT_END) ? 8'h5A : lat_sh[NB_LPAD-1 -: 8];
        if (!i_tx_full) begin
          o_tx_wr = 1'b1;
          if (idx == LAT_END) begin
            idx_n = '0;
            state_n = IDLE;
          end else begin
            idx_n = idx + 16'd1;
          end
        end
      end
      CPU_RST: begin
        o_cpu_reset = 1'b1;
        idx_n = '0;
        byte_cnt_n = '0;
        word_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_step_unit.sv
// tb/tb_debug_step_unit.sv - directed self-checking bench for debug_step_unit
module tb_debug_step_unit;

  logic clk = 1'b0;
  logic i_du_reset, i_rx_empty, i_tx_full, i_halt;
  logic [7:0] i_rx_data;
  logic o_rx_rd, o_tx_wr, o_cpu_en, o_cpu_reset, o_imem_we;
  logic [7:0] o_tx_data;
  logic [31:0] o_imem_addr, o_imem_data, i_reg_data, o_mem_addr, i_mem_data;
  logic [4:0] o_reg_addr;
  logic [340:0] i_latch_data;
  logic [3:0] o_state;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [31:0] we_addr[$];
  logic [31:0] we_data[$];
  int n_pass = 0, n_total = 0;
  int cpu_en_cnt = 0, rst_pulses = 0, bad_push = 0, bad_pop = 0;

  always #5 clk = ~clk;

  assign i_reg_data = 32'h10203040 + 32'(o_reg_addr);
  assign i_mem_data = 32'hC0DE0000 ^ o_mem_addr;
  assign i_latch_data = {5'h1F, {42{8'hC3}}};

  debug_step_unit dut (
    .i_du_clk(clk), .i_du_reset(i_du_reset),
    .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data), .o_rx_rd(o_rx_rd),
    .i_tx_full(i_tx_full), .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data),
    .i_halt(i_halt), .o_cpu_en(o_cpu_en), .o_cpu_reset(o_cpu_reset),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .i_latch_data(i_latch_data), .o_state(o_state)
  );

  task automatic rx_update();
    i_rx_empty = (rx_q.size() == 0);
    i_rx_data = i_rx_empty ? 8'h00 : rx_q[0];
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    rx_update();
  endtask

  // Sample outputs mid-cycle, then let the edge happen and model the FIFO pop.
  task automatic step();
    logic pop;
    logic [7:0] dropped;
    @(negedge clk);
    if (o_tx_wr) begin
      if (i_tx_full) bad_push++;
      else tx_q.push_back(o_tx_data);
    end
    if (o_cpu_en) cpu_en_cnt++;
    if (o_cpu_reset) rst_pulses++;
    if (o_imem_we) begin
      we_addr.push_back(o_imem_addr);
      we_data.push_back(o_imem_data);
    end
    pop = o_rx_rd;
    if (pop && i_rx_empty) bad_pop++;
    @(posedge clk);
    #1;
    if (pop && rx_q.size() > 0) dropped = rx_q.pop_front();
    rx_update();
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int k = 0; k < budget && tx_q.size() < n; k++) step();
  endtask

  task automatic build_exp();
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    for (int r = 0; r < 32; r++) begin
      w = 32'h10203040 + r;
      exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
    end
    for (int m = 0; m < 32; m++) begin
      w = 32'hC0DE0000 ^ (m * 4);
      exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
    end
    exp_q.push_back(8'h1F);
    for (int l = 0; l < 42; l++) exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
  endtask

  function automatic int dump_errs();
    int e = 0;
    if (tx_q.size() != exp_q.size()) e++;
    for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++)
      if (tx_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    i_du_reset = 1'b1;
    step(); step();
    n_total++;
    if (o_state !== 4'd0) $display("FAIL reset_state got %0d want 0", o_state);
    else n_pass++;
    n_total++;
    if ({o_tx_wr, o_rx_rd, o_cpu_en, o_cpu_reset, o_imem_we} !== 5'b0)
      $display("FAIL reset_strobes got %b want 00000", {o_tx_wr, o_rx_rd, o_cpu_en, o_cpu_reset, o_imem_we});
    else n_pass++;
    n_total++;
    if ({o_imem_addr, o_mem_addr, o_reg_addr, o_tx_data} !== 77'b0)
      $display("FAIL reset_addr got %h/%h/%h/%h want 0", o_imem_addr, o_mem_addr, o_reg_addr, o_tx_data);
    else n_pass++;
    i_du_reset = 1'b0;
    step();
  endtask

  task automatic test_load();
    int n_aa = 0;
    tx_q.delete(); we_addr.delete(); we_data.delete();
    send(8'h02);
    send(8'h20); send(8'h01); send(8'h00); send(8'h05);
    send(8'hFC); send(8'h00); send(8'h00); send(8'h00);
    repeat (40) step();
    foreach (tx_q[i]) if (tx_q[i] === 8'hAA) n_aa++;
    n_total++;
    if (tx_q.size() != 9 || n_aa != 9) $display("FAIL load_acks got %0d bytes %0d AA want 9/9", tx_q.size(), n_aa);
    else n_pass++;
    n_total++;
    if (we_addr.size() != 2) $display("FAIL load_writes got %0d want 2", we_addr.size());
    else n_pass++;
    n_total++;
    if (we_addr.size() < 1 || we_addr[0] !== 32'h0 || we_data[0] !== 32'h20010005)
      $display("FAIL load_word0 got %0d entries want addr 0 data 20010005", we_addr.size());
    else n_pass++;
    n_total++;
    if (we_addr.size() < 2 || we_addr[1] !== 32'h4 || we_data[1] !== 32'hFC000000)
      $display("FAIL load_word1 got %0d entries want addr 4 data fc000000", we_addr.size());
    else n_pass++;
    n_total++;
    if (o_state !== 4'd0 || rx_q.size() != 0) $display("FAIL load_end got state %0d rx %0d want 0/0", o_state, rx_q.size());
    else n_pass++;
  endtask

  task automatic test_run();
    tx_q.delete(); cpu_en_cnt = 0;
    send(8'h05);
    for (int k = 0; k < 100 && cpu_en_cnt < 10; k++) step();
    i_halt = 1'b1;
    step();
    wait_tx(301, 2000);
    repeat (5) step();
    i_halt = 1'b0;
    n_total++;
    if (cpu_en_cnt != 10) $display("FAIL run_cpu_en got %0d want 10", cpu_en_cnt);
    else n_pass++;
    n_total++;
    if (tx_q.size() != 301) $display("FAIL run_len got %0d want 301", tx_q.size());
    else n_pass++;
    n_total++;
    if ({tx_q[1], tx_q[2], tx_q[3], tx_q[4]} !== 32'h10203040)
      $display("FAIL run_reg0 got %h%h%h%h want 10203040", tx_q[1], tx_q[2], tx_q[3], tx_q[4]);
    else n_pass++;
    n_total++;
    if (tx_q[tx_q.size()-1] !== 8'h5A) $display("FAIL run_term got %h want 5a", tx_q[tx_q.size()-1]);
    else n_pass++;
    n_total++;
    if (dump_errs() != 0) $display("FAIL run_stream got %0d errors want 0", dump_errs());
    else n_pass++;
    n_total++;
    if (o_state !== 4'd0) $display("FAIL run_idle got %0d want 0", o_state);
    else n_pass++;
  endtask

  task automatic test_step();
    tx_q.delete(); cpu_en_cnt = 0;
    send(8'h06);
    wait_tx(301, 2000);
    repeat (5) step();
    n_total++;
    if (cpu_en_cnt != 1) $display("FAIL step_cpu_en got %0d want 1", cpu_en_cnt);
    else n_pass++;
    n_total++;
    if (dump_errs() != 0) $display("FAIL step_stream got %0d errors len %0d want 0/301", dump_errs(), tx_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int sz;
    tx_q.delete(); bad_push = 0;
    send(8'h06);
    wait_tx(100, 500);
    i_tx_full = 1'b1;
    sz = tx_q.size();
    repeat (5) step();
    n_total++;
    if (bad_push != 0 || tx_q.size() != sz)
      $display("FAIL bp_hold got %0d pushes growth %0d want 0/0", bad_push, tx_q.size() - sz);
    else n_pass++;
    i_tx_full = 1'b0;
    wait_tx(301, 2000);
    repeat (5) step();
    n_total++;
    if (dump_errs() != 0) $display("FAIL bp_stream got %0d errors len %0d want 0/301", dump_errs(), tx_q.size());
    else n_pass++;
  endtask

  task automatic test_nak_cpurst();
    logic [7:0] got;
    tx_q.delete(); rst_pulses = 0;
    send(8'h77);
    repeat (10) step();
    got = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    n_total++;
    if (tx_q.size() != 1 || got !== 8'h55) $display("FAIL nak got %0d bytes first %h want 1/55", tx_q.size(), got);
    else n_pass++;
    n_total++;
    if (o_state !== 4'd0) $display("FAIL nak_idle got %0d want 0", o_state);
    else n_pass++;
    tx_q.delete();
    send(8'h0C);
    repeat (10) step();
    n_total++;
    if (rst_pulses != 1 || tx_q.size() != 0) $display("FAIL cpurst got %0d pulses %0d tx want 1/0", rst_pulses, tx_q.size());
    else n_pass++;
    n_total++;
    if (bad_pop != 0) $display("FAIL empty_pop got %0d want 0", bad_pop);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    tx_q.delete();
    send(8'h06);
    wait_tx(140, 500);
    n_total++;
    if (o_state !== 4'd8) $display("FAIL mid_in_mem got %0d want 8", o_state);
    else n_pass++;
    i_du_reset = 1'b1;
    step();
    n_total++;
    if (o_state !== 4'd0) $display("FAIL mid_state got %0d want 0", o_state);
    else n_pass++;
    n_total++;
    if ({o_tx_wr, o_rx_rd, o_cpu_en, o_cpu_reset, o_imem_we, o_tx_data, o_mem_addr, o_reg_addr, o_imem_addr} !== 82'b0)
      $display("FAIL mid_outputs got %b%b%b%b%b %h %h %h %h want 0", o_tx_wr, o_rx_rd, o_cpu_en, o_cpu_reset,
               o_imem_we, o_tx_data, o_mem_addr, o_reg_addr, o_imem_addr);
    else n_pass++;
    i_du_reset = 1'b0;
    i_halt = 1'b1;
    step();
    tx_q.delete();
    send(8'h05);
    wait_tx(301, 2000);
    repeat (5) step();
    i_halt = 1'b0;
    n_total++;
    if (dump_errs() != 0) $display("FAIL mid_redump got %0d errors len %0d want 0/301", dump_errs(), tx_q.size());
    else n_pass++;
  endtask

  initial begin
    i_du_reset = 1'b1; i_tx_full = 1'b0; i_halt = 1'b0;
    rx_update();
    build_exp();
    test_reset();
    test_load();
    test_run();
    test_step();
    test_backpressure();
    test_nak_cpurst();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
